armv8_regfile_unit: RTL and testbench
=====================================

Name: armv8_regfile_unit

Overview:
- LEGv8/ARMv8-style integer register file: 32 x 64-bit registers, two asynchronous read ports and one synchronous write port.
- X31 (XZR) is hard-wired to zero.
- Also contains the REG2LOC operand-address mux. It selects the second read-register field (Rm for R-type, Rt for CBZ/STUR) in the decode stage.
- Sits between instruction decode and the ALU/data-memory path of the single-cycle core.

Parameters:
- DATA_WIDTH, 64, width of each register and of the data ports.
- ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers).
- ZERO_REG, 31, index of the hard-wired zero register.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- REGWRITE  input  1  write enable.
- write_reg  input  ADDR_WIDTH  destination register index.
- writeData  input  DATA_WIDTH  data to write.
- read1  input  ADDR_WIDTH  read port 1 index.
- read2  input  ADDR_WIDTH  read port 2 index.
- read_data1  output  DATA_WIDTH  contents of register[read1].
- read_data2  output  DATA_WIDTH  contents of register[read2].
- rm  input  ADDR_WIDTH  Rm field (instr[20:16]).
- rt  input  ADDR_WIDTH  Rt field (instr[4:0]).
- REG2LOC  input  1  mux select: 0 selects rm, 1 selects rt.
- mux_out  output  ADDR_WIDTH  selected register index.

Behaviour:
- Storage:
  - Array reg_data[0..31] of DATA_WIDTH bits.
  - The array is named reg_data so benches may probe it hierarchically.
- Reset:
  - rst=1 at a rising clk edge clears all 32 registers to 0.
  - Reset has priority over any write in the same cycle.
  - Outputs are combinational, so read_data1/2 show 0 from the cycle after the reset edge.
- Write:
  - On rising clk with rst=0 and REGWRITE=1, reg_data[write_reg] <= writeData.
  - Latency 1 edge.
  - REGWRITE=0: no register changes.
- Zero register:
  - A write with write_reg == ZERO_REG is silently discarded.
  - reg_data[31] stays 0 at all times, including immediately after such a write.
  - Reads of index 31 return 0.
- Read:
  - Purely combinational: read_dataN = reg_data[readN] (0 for index 31).
  - Both ports are independent; read1 == read2 is legal and both return the same value.
- Read-during-write:
  - No bypass.
  - Reading write_reg in the same cycle as the write returns the old value until the clock edge, then the new value.
- Register mux:
  - Combinational: mux_out = REG2LOC ? rt : rm.
  - Independent of clk/rst.
  - Not internally connected to read2; the integrating core wires mux_out to read2.
- No X propagation:
  - Every register has a defined value after the first reset.
  - Before any reset, contents are unspecified.
- Widths:
  - No truncation/extension; writeData is stored verbatim.
  - Indices use all ADDR_WIDTH bits, with no aliasing.

Test Plan:
- Reset then read: rst=1 for one edge, then read1=1, read2=2 -> read_data1=0, read_data2=0.
- Basic write/read: REGWRITE=1, write_reg=2, writeData=99999, one edge; then read1=1, read2=2 -> read_data1=0, read_data2=99999.
- Zero-register protection: REGWRITE=1, write_reg=31, writeData=99999, one edge -> reg_data[31]=0 and read of index 31 returns 0.
- Write disabled / reset priority:
  - REGWRITE=0, write_reg=5, writeData=0xDEAD, one edge -> X5 remains 0.
  - Then rst=1 with REGWRITE=1, write_reg=3, writeData=7 -> X3=0 after the edge.
- Read-during-write: read1=4 while writing X4=0xFFFF_FFFF_FFFF_FFFF -> read_data1=0 before the edge, all-ones after it.
- Mux: rm=0, rt=1 -> REG2LOC=0 gives mux_out=0, REG2LOC=1 gives mux_out=1; also rm=31, rt=17 -> REG2LOC=0 gives 31, REG2LOC=1 gives 17.

Source files
------------

// File: rtl/armv8_regfile_unit.sv
// 32 x 64-bit integer register file (X31 reads as zero) plus the REG2LOC read-address mux.
// Reads and mux are combinational; writes land on the next rising edge; no flow control.
module armv8_regfile_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  REGWRITE,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] read1,
  input  logic [ADDR_WIDTH-1:0] read2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic [ADDR_WIDTH-1:0] rm,
  input  logic [ADDR_WIDTH-1:0] rt,
  input  logic                  REG2LOC,
  output logic [ADDR_WIDTH-1:0] mux_out
);

  localparam int                  NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZR_IDX = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] reg_data [0:NUM_REGS-1];

  logic wr_vld;
  assign wr_vld = REGWRITE && (write_reg != ZR_IDX);

  // Reset wins over a same-cycle write; XZR writes are dropped so its cell stays 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_data[i] <= '0;
      end
    end else if (wr_vld) begin
      reg_data[write_reg] <= writeData;
    end
  end

  // The explicit zero on XZR keeps reads clean even before the first reset.
  always_comb begin
    read_data1 = (read1 == ZR_IDX) ? '0 : reg_data[read1];
    read_data2 = (read2 == ZR_IDX) ? '0 : reg_data[read2];
  end

  assign mux_out = REG2LOC ? rt : rm;

endmodule

// File: tb/tb_armv8_regfile_unit.sv
// Directed bench: stimulus queues expected values, a negedge monitor pops and compares them.
module tb_armv8_regfile_unit;

  localparam int DW = 64;
  localparam int AW = 5;

  localparam int K_RD1 = 0;
  localparam int K_RD2 = 1;
  localparam int K_MUX = 2;
  localparam int K_X31 = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          REGWRITE;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] writeData;
  logic [AW-1:0] read1;
  logic [AW-1:0] read2;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;
  logic [AW-1:0] rm;
  logic [AW-1:0] rt;
  logic          REG2LOC;
  logic [AW-1:0] mux_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;
    logic [DW-1:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  armv8_regfile_unit dut (
    .clk        (clk),
    .rst        (rst),
    .REGWRITE   (REGWRITE),
    .write_reg  (write_reg),
    .writeData  (writeData),
    .read1      (read1),
    .read2      (read2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .rm         (rm),
    .rt         (rt),
    .REG2LOC    (REG2LOC),
    .mux_out    (mux_out)
  );

  always #5 clk = ~clk;

  task automatic push(input int kind, input logic [DW-1:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are sampled mid-cycle, well away from the write edge.
  always @(negedge clk) begin
    exp_t          e;
    logic [DW-1:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_RD1:   act = read_data1;
        K_RD2:   act = read_data2;
        K_MUX:   act = DW'(mux_out);
        default: act = dut.reg_data[31];
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    rst = 1'b1; REGWRITE = 1'b0; write_reg = '0; writeData = '0;
    read1 = '0; read2 = '0; rm = '0; rt = '0; REG2LOC = 1'b0;
    tick();

    // Reset state
    rst = 1'b0; read1 = 5'd1; read2 = 5'd2;
    push(K_RD1, 64'd0, "reset_rd1");
    push(K_RD2, 64'd0, "reset_rd2");
    push(K_X31, 64'd0, "reset_x31");
    REGWRITE = 1'b1; write_reg = 5'd2; writeData = 64'd99999;
    tick();

    // Basic write/read
    REGWRITE = 1'b0;
    push(K_RD1, 64'd0, "basic_rd1");
    push(K_RD2, 64'd99999, "basic_rd2");
    REGWRITE = 1'b1; write_reg = 5'd31; writeData = 64'd99999;
    tick();

    // Zero register protection
    REGWRITE = 1'b0; read1 = 5'd31; read2 = 5'd31;
    push(K_X31, 64'd0, "xzr_store");
    push(K_RD1, 64'd0, "xzr_rd1");
    push(K_RD2, 64'd0, "xzr_rd2");
    write_reg = 5'd5; writeData = 64'hDEAD;
    tick();

    // Write disabled
    read1 = 5'd5; read2 = 5'd2;
    push(K_RD1, 64'd0, "wen0_x5");
    push(K_RD2, 64'd99999, "wen0_x2");
    REGWRITE = 1'b1; write_reg = 5'd3; writeData = 64'h0123_4567_89AB_CDEF;
    tick();
    write_reg = 5'd30; writeData = 64'h8000_0000_0000_0001;
    tick();
    write_reg = 5'd1; writeData = 64'h5A5A_5A5A_5A5A_5A5A;
    tick();

    // Distinct patterns, aliasing, same index on both ports
    REGWRITE = 1'b0; read1 = 5'd3; read2 = 5'd30;
    push(K_RD1, 64'h0123_4567_89AB_CDEF, "pat_x3");
    push(K_RD2, 64'h8000_0000_0000_0001, "pat_x30");
    tick();
    read1 = 5'd17; read2 = 5'd1;
    push(K_RD1, 64'd0, "alias_x17");
    push(K_RD2, 64'h5A5A_5A5A_5A5A_5A5A, "alias_x1");
    tick();
    read1 = 5'd3; read2 = 5'd3;
    push(K_RD1, 64'h0123_4567_89AB_CDEF, "same_rd1");
    push(K_RD2, 64'h0123_4567_89AB_CDEF, "same_rd2");
    rst = 1'b1; REGWRITE = 1'b1; write_reg = 5'd3; writeData = 64'd7;
    tick();

    // Reset priority over a write
    rst = 1'b0; REGWRITE = 1'b0; read1 = 5'd3; read2 = 5'd2;
    push(K_RD1, 64'd0, "rstprio_x3");
    push(K_RD2, 64'd0, "rstprio_x2");
    tick();

    // Read during write: old value before the edge, new value after
    REGWRITE = 1'b1; write_reg = 5'd4; writeData = '1; read1 = 5'd4;
    push(K_RD1, 64'd0, "rdw_before");
    tick();
    REGWRITE = 1'b0;
    push(K_RD1, 64'hFFFF_FFFF_FFFF_FFFF, "rdw_after");
    tick();

    // REG2LOC mux
    rm = 5'd0; rt = 5'd1; REG2LOC = 1'b0;
    push(K_MUX, 64'd0, "mux_rm0");
    tick();
    REG2LOC = 1'b1;
    push(K_MUX, 64'd1, "mux_rt1");
    tick();
    rm = 5'd31; rt = 5'd17; REG2LOC = 1'b0;
    push(K_MUX, 64'd31, "mux_rm31");
    tick();
    REG2LOC = 1'b1; rst = 1'b1;
    push(K_MUX, 64'd17, "mux_rt17_rst");
    tick();
    rst = 1'b0;
    tick();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
